// File: rtl/OoO_pkg.sv
// ----------------------------------------------------------------------------
// OoO_pkg
// Shared types and default sizes for the out-of-order scoreboard slice.
//   ScoreboardDepth / WriteBackPorts : defaults for scoreboard_rob parameters
//   decoder_t   : instruction handed over at issue
//   writeback_t : one functional-unit result (trans_id is TransIdW wide)
//   sb_entry_t  : scoreboard payload as presented at the commit port
// ----------------------------------------------------------------------------
package OoO_pkg;

   localparam int unsigned ScoreboardDepth = 4;
   localparam int unsigned WriteBackPorts  = 2;
   localparam int unsigned TransIdW        = $clog2(ScoreboardDepth);

   typedef enum logic [2:0] {
      FU_NONE   = 3'd0,
      FU_ALU    = 3'd1,
      FU_LSU    = 3'd2,
      FU_BRANCH = 3'd3,
      FU_MULT   = 3'd4
   } fu_t;

   typedef struct packed {
      logic       valid;
      logic [7:0] cause;
   } exception_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      fu_t         fu;
      logic [7:0]  op;
      exception_t  ex;
   } decoder_t;

   typedef struct packed {
      logic                valid;
      logic [TransIdW-1:0] trans_id;
      logic [31:0]         data;
      logic                ex_valid;
   } writeback_t;

   typedef struct packed {
      logic [31:0]         pc;
      logic [4:0]          rd;
      fu_t                 fu;
      logic [7:0]          op;
      logic [31:0]         result;
      logic                ex_valid;
      logic [TransIdW-1:0] trans_id;
   } sb_entry_t;

endpackage

// File: rtl/sb_rs_lookup.sv
// ----------------------------------------------------------------------------
// sb_rs_lookup
// Finds the youngest in-flight producer of register rs, scanning entries
// from head (oldest) to head+Depth-1 (youngest).
//   head      : oldest entry index
//   rs        : source register looked up (x0 never matches)
//   issued    : per-entry in-flight flag
//   done      : per-entry result-available flag
//   rd        : per-entry destination register
//   result    : per-entry result
//   busy      : youngest producer has not written back yet
//   fwd_valid : youngest producer has completed
//   fwd_data  : its result, 0 when nothing matches
// ----------------------------------------------------------------------------
module sb_rs_lookup #(
   parameter  int unsigned Depth = 4,
   localparam int unsigned IdxW  = $clog2(Depth)
) (
   input  logic [IdxW-1:0]         head,
   input  logic [4:0]              rs,
   input  logic [Depth-1:0]        issued,
   input  logic [Depth-1:0]        done,
   input  logic [Depth-1:0][4:0]   rd,
   input  logic [Depth-1:0][31:0]  result,
   output logic                    busy,
   output logic                    fwd_valid,
   output logic [31:0]             fwd_data
);

   logic            match;
   logic            sel_done;
   logic [31:0]     sel_data;
   logic [IdxW-1:0] idx;

   // age-ordered scan; a later (younger) match overrides an earlier one
   always_comb begin
      match    = 1'b0;
      sel_done = 1'b0;
      sel_data = 32'd0;
      idx      = '0;
      for (int i = 0; i < int'(Depth); i++) begin
         idx = head + IdxW'(i);
         if (issued[idx] && (rd[idx] == rs) && (rs != 5'd0)) begin
            match    = 1'b1;
            sel_done = done[idx];
            sel_data = result[idx];
         end else begin
            match    = match;
         end
      end
      busy      = match & ~sel_done;
      fwd_valid = match & sel_done;
      fwd_data  = match ? sel_data : 32'd0;
   end

endmodule

// File: rtl/scoreboard_rob.sv
// ----------------------------------------------------------------------------
// scoreboard_rob
// In-order-commit scoreboard / reorder buffer (circular, Depth entries).
//   clock, reset           : clock, asynchronous active-high reset
//   flush_i                : discard every entry at the next edge
//   issue_*                : allocation handshake; issue_trans_id_o is tail
//   wb_i                   : NrWbPorts writeback results (highest port wins)
//   rs1_i/rs2_i, rs*_busy_o, rs*_fwd_valid_o, rs*_fwd_data_o : operand lookup
//   commit_valid_o, commit_ack_i, commit_o : head entry retirement
//   empty_o, count_o       : occupancy
// ----------------------------------------------------------------------------
module scoreboard_rob
   import OoO_pkg::*;
#(
   parameter  int unsigned Depth     = ScoreboardDepth,
   parameter  int unsigned NrWbPorts = WriteBackPorts,
   localparam int unsigned IdxW      = $clog2(Depth)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            flush_i,
   input  logic                            issue_valid_i,
   output logic                            issue_ready_o,
   input  decoder_t                        issue_instr_i,
   output logic [IdxW-1:0]                 issue_trans_id_o,
   input  writeback_t [NrWbPorts-1:0]      wb_i,
   input  logic [4:0]                      rs1_i,
   input  logic [4:0]                      rs2_i,
   output logic                            rs1_busy_o,
   output logic                            rs2_busy_o,
   output logic                            rs1_fwd_valid_o,
   output logic                            rs2_fwd_valid_o,
   output logic [31:0]                     rs1_fwd_data_o,
   output logic [31:0]                     rs2_fwd_data_o,
   output logic                            commit_valid_o,
   input  logic                            commit_ack_i,
   output sb_entry_t                       commit_o,
   output logic                            empty_o,
   output logic [IdxW:0]                   count_o
);

   logic [IdxW-1:0]          head_r;
   logic [IdxW-1:0]          tail_r;
   logic [IdxW:0]            count_r;
   logic [Depth-1:0]         issued_r;
   logic [Depth-1:0]         done_r;
   sb_entry_t                mem_r [Depth];

   logic                     issue_fire_s;
   logic                     commit_fire_s;
   logic [Depth-1:0]         wb_hit_s;
   logic [Depth-1:0]         wb_exv_s;
   logic [Depth-1:0][31:0]   wb_data_s;
   logic [Depth-1:0][4:0]    ent_rd_s;
   logic [Depth-1:0][31:0]   ent_res_s;

   // full check ignores a same-cycle commit so the ready path stays short
   assign issue_ready_o    = (count_r < (IdxW+1)'(Depth));
   assign issue_fire_s     = issue_valid_i & issue_ready_o;
   assign commit_valid_o   = issued_r[head_r] & done_r[head_r];
   assign commit_fire_s    = commit_valid_o & commit_ack_i;
   assign commit_o         = mem_r[head_r];
   assign issue_trans_id_o = tail_r;
   assign empty_o          = (count_r == '0);
   assign count_o          = count_r;

   // per-entry writeback decode; ascending port order lets the highest port win
   always_comb begin
      wb_hit_s  = '0;
      wb_exv_s  = '0;
      wb_data_s = '0;
      for (int k = 0; k < int'(NrWbPorts); k++) begin
         if (wb_i[k].valid) begin
            wb_hit_s[IdxW'(wb_i[k].trans_id)]  = 1'b1;
            wb_exv_s[IdxW'(wb_i[k].trans_id)]  = wb_i[k].ex_valid;
            wb_data_s[IdxW'(wb_i[k].trans_id)] = wb_i[k].data;
         end else begin
            wb_hit_s = wb_hit_s;
         end
      end
   end

   // pointers, occupancy and per-entry status; flush behaves like reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_r   <= '0;
         tail_r   <= '0;
         count_r  <= '0;
         issued_r <= '0;
         done_r   <= '0;
      end else if (flush_i) begin
         head_r   <= '0;
         tail_r   <= '0;
         count_r  <= '0;
         issued_r <= '0;
         done_r   <= '0;
      end else begin
         for (int e = 0; e < int'(Depth); e++) begin
            if (wb_hit_s[e] && issued_r[e]) begin
               done_r[e] <= 1'b1;
            end
         end
         if (commit_fire_s) begin
            issued_r[head_r] <= 1'b0;
            head_r           <= head_r + IdxW'(1);
         end
         if (issue_fire_s) begin
            issued_r[tail_r] <= 1'b1;
            done_r[tail_r]   <= issue_instr_i.ex.valid;
            tail_r           <= tail_r + IdxW'(1);
         end
         case ({issue_fire_s, commit_fire_s})
            2'b10:   count_r <= count_r + (IdxW+1)'(1);
            2'b01:   count_r <= count_r - (IdxW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // entry payload; no reset needed because issued/done gate every use
   always_ff @(posedge clock) begin
      if (!flush_i) begin
         for (int e = 0; e < int'(Depth); e++) begin
            if (wb_hit_s[e] && issued_r[e]) begin
               mem_r[e].result   <= wb_data_s[e];
               mem_r[e].ex_valid <= wb_exv_s[e];
            end
         end
         if (issue_fire_s) begin
            mem_r[tail_r].pc       <= issue_instr_i.pc;
            mem_r[tail_r].rd       <= issue_instr_i.rd;
            mem_r[tail_r].fu       <= issue_instr_i.fu;
            mem_r[tail_r].op       <= issue_instr_i.op;
            mem_r[tail_r].result   <= 32'd0;
            mem_r[tail_r].ex_valid <= issue_instr_i.ex.valid;
            mem_r[tail_r].trans_id <= TransIdW'(tail_r);
         end
      end
   end

   // flatten payload fields for the operand lookups
   always_comb begin
      ent_rd_s  = '0;
      ent_res_s = '0;
      for (int e = 0; e < int'(Depth); e++) begin
         ent_rd_s[e]  = mem_r[e].rd;
         ent_res_s[e] = mem_r[e].result;
      end
   end

   sb_rs_lookup #(.Depth(Depth)) u_rs1_lookup (
      .head      (head_r),
      .rs        (rs1_i),
      .issued    (issued_r),
      .done      (done_r),
      .rd        (ent_rd_s),
      .result    (ent_res_s),
      .busy      (rs1_busy_o),
      .fwd_valid (rs1_fwd_valid_o),
      .fwd_data  (rs1_fwd_data_o)
   );

   sb_rs_lookup #(.Depth(Depth)) u_rs2_lookup (
      .head      (head_r),
      .rs        (rs2_i),
      .issued    (issued_r),
      .done      (done_r),
      .rd        (ent_rd_s),
      .result    (ent_res_s),
      .busy      (rs2_busy_o),
      .fwd_valid (rs2_fwd_valid_o),
      .fwd_data  (rs2_fwd_data_o)
   );

endmodule

// File: doc/scoreboard_rob.md
SCOREBOARD_ROB -- requirements
Module: scoreboard_rob

Interface
REQ-001 The block SHALL have parameter Depth, default 4, meaning the entry count (power of two, at least 2).
REQ-002 The block SHALL have parameter NrWbPorts, default 2, meaning the number of writeback ports.
REQ-003 The block SHALL have derived localparam IdxW = $clog2(Depth), meaning the trans_id width.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port flush_i, input, 1 bit: discard all entries.
REQ-007 The block SHALL have port issue_valid_i, input, 1 bit, and port issue_ready_o, output, 1 bit: issue handshake.
REQ-008 The block SHALL have port issue_instr_i, input, decoder_t: instruction to allocate.
REQ-009 The block SHALL have port issue_trans_id_o, output, IdxW bits: id that the current issue receives (tail pointer).
REQ-010 The block SHALL have port wb_i, input, NrWbPorts x writeback_t: FU results.
REQ-011 The block SHALL have ports rs1_i and rs2_i, input, 5 bits each: operand lookup registers.
REQ-012 The block SHALL have ports rs1_busy_o and rs2_busy_o, output, 1 bit each: an in-flight producer exists and has not written back.
REQ-013 The block SHALL have ports rs1_fwd_valid_o and rs2_fwd_valid_o (1 bit) and rs1_fwd_data_o and rs2_fwd_data_o (32 bits), all outputs: youngest producer has completed, and its result.
REQ-014 The block SHALL have port commit_valid_o, output, 1 bit, and port commit_ack_i, input, 1 bit: commit handshake.
REQ-015 The block SHALL have port commit_o, output, sb_entry_t: head entry (pc, rd, fu, op, result, ex_valid, trans_id).
REQ-016 The block SHALL have ports empty_o, output, 1 bit, and count_o, output, IdxW+1 bits: occupancy.

Function
REQ-017 The block SHALL be a circular buffer with head, tail and count registers, with pointers wrapping modulo Depth.
REQ-018 The block SHALL drive issue_ready_o = (count < Depth), independent of commit in the same cycle.
REQ-019 On issue_valid_i and issue_ready_o, the block SHALL write issue_instr_i into entry[tail] with issued=1 and done=0; result and ex_valid SHALL be cleared unless issue_instr_i.ex is valid, in which case done=1 and ex_valid=1; the block SHALL then increment tail.
REQ-020 On each wb_i[k].valid, the block SHALL set done=1, result=data and ex_valid for entry[trans_id] only if that entry is issued; writeback to a non-issued entry SHALL be ignored.
REQ-021 When two ports write the same trans_id in one cycle, the block SHALL let the highest port index win.
REQ-022 The block SHALL drive commit_valid_o = entry[head].issued & entry[head].done, and commit_o SHALL be entry[head] combinationally.
REQ-023 On commit_valid_o and commit_ack_i, the block SHALL clear entry[head].issued and increment head; commit_ack_i without commit_valid_o SHALL be ignored.
REQ-024 On simultaneous issue and commit, the block SHALL perform both and leave count unchanged; issue when full SHALL be blocked even if commit occurs.
REQ-025 Operand lookup SHALL be combinational over issued entries with rd == rs and rs != 0, selecting the entry youngest relative to head.
REQ-026 Operand lookup SHALL set busy = match & !done, fwd_valid = match & done, and fwd_data = result, and SHALL drive fwd_data to 0 when no match.
REQ-027 Operand lookup SHALL NOT bypass same-cycle wb_i; a result becomes visible the cycle after writeback.
REQ-028 flush_i SHALL clear all issued bits and zero head, tail and count at the next edge, overriding issue, writeback and commit in that cycle.
REQ-029 Issue-to-commit SHALL take a minimum of 2 cycles: issue edge, writeback edge, then commit_valid_o is visible.

Reset
REQ-030 While reset is high, the block SHALL asynchronously clear head, tail, count and all issued/done bits.
REQ-031 Under reset, the outputs SHALL be: issue_ready_o=1, issue_trans_id_o=0, commit_valid_o=0, empty_o=1, count_o=0, and all busy and fwd_valid outputs 0.
REQ-032 Entry payload fields SHALL NOT need reset.
REQ-033 Reset asserted mid-operation SHALL discard all entries identically to flush.

Structure
REQ-034 sb_entry_t, and writeback_t re-parametrised to an IdxW-wide trans_id, SHALL live in OoO_pkg.
REQ-035 ScoreboardDepth and WriteBackPorts in OoO_pkg SHALL become the parameter defaults.
REQ-036 The youngest-match search SHALL be one sub-module, sb_rs_lookup, instantiated twice (rs1 and rs2).

Verification
REQ-037 Verification SHALL cover: issue 4 instrs (Depth=4) -> ids 0,1,2,3, issue_ready_o=0, count_o=4; 5th issue is held off.
REQ-038 Verification SHALL cover: writebacks out of order to ids 2,0,1 -> commit_o.trans_id sequence 0,1,2, each only after its own writeback.
REQ-039 Verification SHALL cover: id0 rd=5 done with result 0xAA and id2 rd=5 pending, with rs1_i=5 -> rs1_busy_o=1, rs1_fwd_valid_o=0; then wb id2 with 0xBB -> next cycle rs1_fwd_valid_o=1, data 0xBB.
REQ-040 Verification SHALL cover: full buffer, commit_ack_i and issue_valid_i in the same cycle -> commit happens, issue is not accepted, count_o=3.
REQ-041 Verification SHALL cover: port0 and port1 both writing id1 with 0x11 and 0x22 -> committed result 0x22.
REQ-042 Verification SHALL cover: flush_i together with a wb and an issue -> next cycle empty_o=1 and tail=0, with wraparound checked after 9 issue/commit pairs.
